// File: rtl/word_serializer_if.sv
// Handshake and serial-output bundle for word_serializer.
// rem_out only exists when SER_REMAINDER_EN is defined.
interface word_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_bit;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_last;
    logic             busy;
`ifdef SER_REMAINDER_EN
    logic [1:0]       rem_out;
`endif

    // master = upstream feeder plus downstream consumer; slave = the serializer
    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  ser_bit,
        input  ser_valid,
        input  frame_start,
        input  frame_last,
`ifdef SER_REMAINDER_EN
        input  rem_out,
`endif
        input  busy
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output ser_bit,
        output ser_valid,
        output frame_start,
        output frame_last,
`ifdef SER_REMAINDER_EN
        output rem_out,
`endif
        output busy
    );
endinterface

// File: rtl/word_serializer.sv
// Parallel-to-serial feeder for the mod-3 checker: MSB first, frame_start pulse before each word.
// Optional macro SER_REMAINDER_EN adds rem_out, a golden mod-3 remainder of the emitted bits.
module word_serializer #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    word_serializer_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic             r_serBit;
    logic             r_serValid;
    logic             r_frameStart;
    logic             r_frameLast;
    logic             r_busy;
    logic             w_loadReady;
    logic             w_accept;

    // r_count holds how many bits remain after the one currently on ser_bit
    assign w_loadReady = (r_state == IDLE) || ((r_state == SHIFT) && (r_count == '0));
    assign w_accept    = bus.load_valid && w_loadReady;

`ifdef SER_REMAINDER_EN
    logic [1:0] r_rem;

    function automatic logic [1:0] remNext(input logic [1:0] rem, input logic b);
        logic [1:0] nxt;
        nxt = 2'd0;
        case ({rem, b})
            3'b000:  nxt = 2'd0;
            3'b001:  nxt = 2'd1;
            3'b010:  nxt = 2'd2;
            3'b011:  nxt = 2'd0;
            3'b100:  nxt = 2'd1;
            3'b101:  nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction
`endif

    // The internal shift register runs one position ahead of ser_bit so every output stays registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_count      <= '0;
            r_serBit     <= 1'b0;
            r_serValid   <= 1'b0;
            r_frameStart <= 1'b0;
            r_frameLast  <= 1'b0;
            r_busy       <= 1'b0;
`ifdef SER_REMAINDER_EN
            r_rem        <= 2'd0;
`endif
        end else if (w_accept) begin
            r_state      <= START;
            r_shift      <= bus.load_data;
            r_count      <= LAST_IDX;
            r_serBit     <= 1'b0;
            r_serValid   <= 1'b0;
            r_frameStart <= 1'b1;
            r_frameLast  <= 1'b0;
            r_busy       <= 1'b1;
`ifdef SER_REMAINDER_EN
            r_rem        <= 2'd0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= IDLE;
                end
                START: begin
                    r_state      <= SHIFT;
                    r_frameStart <= 1'b0;
                    r_serValid   <= 1'b1;
                    r_serBit     <= r_shift[WIDTH-1];
                    r_shift      <= r_shift << 1;
                    r_frameLast  <= (r_count == '0);
                end
                SHIFT: begin
`ifdef SER_REMAINDER_EN
                    r_rem <= remNext(r_rem, r_serBit);
`endif
                    if (r_count != '0) begin
                        r_serBit    <= r_shift[WIDTH-1];
                        r_shift     <= r_shift << 1;
                        r_count     <= r_count - CW'(1);
                        r_frameLast <= (r_count == CW'(1));
                    end else begin
                        r_state     <= IDLE;
                        r_serBit    <= 1'b0;
                        r_serValid  <= 1'b0;
                        r_frameLast <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.load_ready  = w_loadReady;
    assign bus.ser_bit     = r_serBit;
    assign bus.ser_valid   = r_serValid;
    assign bus.frame_start = r_frameStart;
    assign bus.frame_last  = r_frameLast;
    assign bus.busy        = r_busy;
`ifdef SER_REMAINDER_EN
    assign bus.rem_out     = r_rem;
`endif
endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Upstream feeder for the serial mod-3 divisibility checker.
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clk.
- Emits a one-cycle frame_start pulse before the first bit. Downstream uses this pulse to reset its remainder FSM, so each word is checked independently.

Parameters:
- WIDTH, 8, bits per word; legal range 1 to 32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- load_valid  input  1  upstream offers load_data
- load_ready  output  1  block can accept a word this cycle
- load_data  input  WIDTH  word to serialize; sampled on accept
- ser_bit  output  1  current serial bit, MSB first; 0 when ser_valid=0
- ser_valid  output  1  ser_bit is a live data bit
- frame_start  output  1  one-cycle pulse one cycle before the first bit of a word
- frame_last  output  1  high with the last (LSB) bit of a word
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE; shift register=0; bit counter=0.
- Output values during reset: ser_bit=0, ser_valid=0, frame_start=0, frame_last=0, busy=0.
- Because load_ready is combinational from state, it is 1 while in reset/IDLE.
- All outputs except load_ready are registered.
- load_ready = (state==IDLE) OR (state==SHIFT AND current bit is the last bit).
- Accept = load_valid AND load_ready, sampled at a rising clk edge.
- On accept: capture load_data into shift register; counter=WIDTH-1; next state=START.
- States:
  - IDLE: ser_valid=0. On accept, go to START; otherwise stay.
  - START: one cycle. frame_start=1, ser_valid=0, ser_bit=0. Always go to SHIFT.
  - SHIFT: ser_valid=1, ser_bit=shift_reg[WIDTH-1]. Each edge: shift left by 1, counter decrements.
  - SHIFT exit (counter==0): frame_last=1 this cycle. On accept go to START (back-to-back, no idle gap); otherwise go to IDLE.
- Latency:
  - Accept at edge N: frame_start is high in cycle N+1; the MSB is on ser_bit in cycle N+2.
  - The LSB is on ser_bit in cycle N+1+WIDTH.
  - Sustained throughput: one word per WIDTH+1 cycles.
- load_valid in START or in non-last SHIFT cycles is ignored; load_data is not sampled. Upstream must hold the word until accepted.
- WIDTH=1: START, then a single SHIFT cycle with frame_last=1 and load_ready=1.
- Reset mid-word aborts the frame: no frame_last is produced, and the next word starts with a fresh START.
- Downstream contract: the checker's rst is tied to frame_start, so it is cleared before the MSB edge and no data bit is lost to reset.

Optional Feature:
- Macro: SER_REMAINDER_EN.
- Defined: adds output rem_out[1:0], a built-in golden model for the downstream checker.
  - rem_out holds the value of the bits emitted so far in the current frame, mod 3, with encoding 00/01/10 for remainder 0/1/2.
  - rem_out is set to 00 during START. It is updated at each SHIFT edge: rem = (2*rem + ser_bit) mod 3.
  - After the last bit, rem_out holds the full-word remainder until the next START.
  - rem_out resets to 00 on rst.
  - rem_out tracks the downstream FSM present state exactly, one cycle after each bit.
- Not defined: no rem_out port and no extra logic.

Test Plan:
- WIDTH=8, load 8'h09 from IDLE:
  - Required: frame_start in cycle N+1, then ser_bit 0,0,0,0,1,0,0,1, with frame_last on the 8th bit.
  - Required: with SER_REMAINDER_EN, rem_out=00 after the last bit.
- Load 8'h07:
  - Required: bits 0,0,0,0,0,1,1,1; final rem_out=01.
  - Required: downstream checker out=0 after the last bit.
- Back-to-back, load_valid held high with 8'hFF then 8'h03:
  - Required: second accept occurs on the frame_last cycle, and the second frame_start immediately follows it.
  - Required: exactly 9 cycles between the two frame_start pulses.
- load_valid asserted during the 3rd SHIFT cycle with new data:
  - Required: load_ready=0 and the word is not captured.
  - Required: the word is accepted only on the frame_last cycle, and the current frame's bits are unchanged.
- rst pulsed asynchronously during the 5th bit of 8'hA5:
  - Required: all outputs go to 0 immediately (except load_ready, which returns to 1), no frame_last occurs, and busy=0.
  - Required: a next load of 8'h03 is serialized cleanly.
- WIDTH=1, load 1'b1:
  - Required: START, then one bit 1 with frame_last=1.
  - Required: rem_out=01.
